// File: rtl/exec_sequencer_pkg.sv
// Shared types for the instruction step sequencer: state encoding, command indices, flag bits.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package exec_sequencer_pkg;

  // Divider iterations; must equal the operand width.
  localparam int DIV_STEPS_DEF = 32;

  typedef enum logic [2:0] {
    SEQ_IDLE = 3'd0,
    SEQ_EXEC = 3'd1,
    SEQ_DIV  = 3'd2,
    SEQ_FIX  = 3'd3,
    SEQ_HOLD = 3'd4
  } seq_state_t;

  // Command indices understood by the execute datapath.
  localparam logic [6:0] CMD_NOP   = 7'd0;
  localparam logic [6:0] CMD_ADD   = 7'd1;
  localparam logic [6:0] CMD_SUB   = 7'd2;
  localparam logic [6:0] CMD_AND   = 7'd3;
  localparam logic [6:0] CMD_OR    = 7'd4;
  localparam logic [6:0] CMD_XOR   = 7'd5;
  localparam logic [6:0] CMD_MOV   = 7'd6;
  localparam logic [6:0] CMD_JECXZ = 7'd7;
  localparam logic [6:0] CMD_DIV   = 7'd8;
  localparam logic [6:0] CMD_IDIV  = 7'd9;

  // EFLAGS bit positions.
  localparam int EFLAGS_CF = 0;
  localparam int EFLAGS_ZF = 6;
  localparam int EFLAGS_SF = 7;
  localparam int EFLAGS_OF = 11;

  // One committed step result.
  typedef struct packed {
    logic [31:0] eflags;
    logic [31:0] next_eip;
    logic [31:0] opnd0;
    logic [31:0] opnd1;
  } res_t;

  // Unsigned magnitude of a two's complement word (0x80000000 maps to itself).
  function automatic logic [31:0] abs32(input logic [31:0] v);
    return v[31] ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/exec_sequencer_if.sv
// Decode-to-writeback step channel: valid/ready request side and valid/ready result side.
// Latency: n/a (wiring only).
// Backpressure: in_ready throttles decode, out_ready throttles the sequencer.
interface exec_sequencer_if;
  logic        in_valid;
  logic        in_ready;
  logic [6:0]  opc;
  logic [31:0] eflags;
  logic        ecx_is_zero;
  logic [31:0] eip;
  logic [3:0]  instr_len;
  logic [31:0] opnd0_r;
  logic [31:0] opnd1_r;
  logic [31:0] opnd2_r;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] o_eflags;
  logic [31:0] next_eip;
  logic [31:0] opnd0_w;
  logic [31:0] opnd1_w;
  logic        fault_de;

  // Decode/writeback environment side.
  modport master (
    output in_valid, opc, eflags, ecx_is_zero, eip, instr_len, opnd0_r, opnd1_r, opnd2_r, out_ready,
    input  in_ready, out_valid, o_eflags, next_eip, opnd0_w, opnd1_w, fault_de
  );

  // Sequencer side.
  modport slave (
    input  in_valid, opc, eflags, ecx_is_zero, eip, instr_len, opnd0_r, opnd1_r, opnd2_r, out_ready,
    output in_ready, out_valid, o_eflags, next_eip, opnd0_w, opnd1_w, fault_de
  );
endinterface

// File: rtl/div_iter.sv
// Restoring shift-subtract divider core: one quotient bit per enabled cycle, W steps per divide.
// Latency: W enabled cycles after load; quot/rem are registers.
// Backpressure: none; the caller gates en.
module div_iter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic [W-1:0] quot,
  output logic [W-1:0] rem
);

  logic [W-1:0] dvs;
  logic [W:0]   trial;

  // Partial remainder is always below the divisor, so W+1 bits hold the trial sign exactly.
  assign trial = {rem, quot[W-1]} - {1'b0, dvs};

  // Load operands, then shift the next dividend bit in and keep the subtraction when it fits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      quot <= '0;
      rem  <= '0;
      dvs  <= '0;
    end else if (load) begin
      quot <= dividend;
      rem  <= '0;
      dvs  <= divisor;
    end else if (en) begin
      if (!trial[W]) begin
        rem  <= trial[W-1:0];
        quot <= {quot[W-2:0], 1'b1};
      end else begin
        rem  <= {rem[W-2:0], quot[W-1]};
        quot <= {quot[W-2:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/execute.sv
// Combinational single-cycle execute datapath: ALU ops, flag update and next-EIP.
// Latency: 0 (pure combinational).
// Backpressure: none.
module execute
  import exec_sequencer_pkg::*;
(
  input  logic [6:0]  opc,
  input  logic [31:0] eflags,
  input  logic        ecx_is_zero,
  input  logic [31:0] eip,
  input  logic [3:0]  instr_len,
  input  logic [31:0] opnd0,
  input  logic [31:0] opnd1,
  input  logic [31:0] opnd2,
  output res_t        res
);

  logic [32:0] sum;
  logic [32:0] diff;
  logic [31:0] seq_eip;

  assign sum     = {1'b0, opnd0} + {1'b0, opnd1};
  assign diff    = {1'b0, opnd0} - {1'b0, opnd1};
  assign seq_eip = eip + {28'd0, instr_len};

  // Select the result per command; DIV/IDIV just pass operands since the sequencer owns the divide.
  always_comb begin
    logic [31:0] r;
    logic        arith;
    logic        logic_op;
    r            = opnd0;
    arith        = 1'b0;
    logic_op     = 1'b0;
    res.eflags   = eflags;
    res.next_eip = seq_eip;
    res.opnd1    = opnd1;
    case (opc)
      CMD_ADD: begin
        r     = sum[31:0];
        arith = 1'b1;
        res.eflags[EFLAGS_CF] = sum[32];
        res.eflags[EFLAGS_OF] = (opnd0[31] == opnd1[31]) && (sum[31] != opnd0[31]);
      end
      CMD_SUB: begin
        r     = diff[31:0];
        arith = 1'b1;
        res.eflags[EFLAGS_CF] = diff[32];
        res.eflags[EFLAGS_OF] = (opnd0[31] != opnd1[31]) && (diff[31] != opnd0[31]);
      end
      CMD_AND: begin r = opnd0 & opnd1; logic_op = 1'b1; end
      CMD_OR:  begin r = opnd0 | opnd1; logic_op = 1'b1; end
      CMD_XOR: begin r = opnd0 ^ opnd1; logic_op = 1'b1; end
      CMD_MOV: r = opnd1;
      CMD_JECXZ: if (ecx_is_zero) res.next_eip = seq_eip + opnd2;
      default: r = opnd0;
    endcase
    if (logic_op) begin
      res.eflags[EFLAGS_CF] = 1'b0;
      res.eflags[EFLAGS_OF] = 1'b0;
    end
    if (arith || logic_op) begin
      res.eflags[EFLAGS_ZF] = (r == 32'd0);
      res.eflags[EFLAGS_SF] = r[31];
    end
    res.opnd0 = r;
  end

endmodule

// File: rtl/exec_sequencer.sv
// One-at-a-time instruction step sequencer: execute path, iterative DIV/IDIV, #DE faults. Optional EXEC_SEQ_PERF_EN adds perf counters.
// Latency: accept->out_valid 1 cycle (single-cycle ops and divide faults), DIV_STEPS+2 cycles for DIV/IDIV.
// Backpressure: result held in HOLD until out_ready; in_ready only in IDLE or HOLD&out_ready.
module exec_sequencer
  import exec_sequencer_pkg::*;
#(
  parameter int DIV_STEPS = DIV_STEPS_DEF
) (
  input  logic              clk,
  input  logic              rst,
  exec_sequencer_if.slave   bus
`ifdef EXEC_SEQ_PERF_EN
  ,
  output logic [31:0]       perf_retired,
  output logic [31:0]       perf_div_cycles
`endif
);

  localparam int CW = $clog2(DIV_STEPS + 1);

  seq_state_t  state, state_nxt, accept_tgt;
  logic        accept, is_div_in, fault_in, div_load, en_div, load_res;
  logic [6:0]  opc_q;
  logic [31:0] eflags_q, eip_q, op0_q, op1_q, op2_q;
  logic [3:0]  len_q;
  logic        ecxz_q, fault_q, qneg_q, rneg_q, fault_de_q;
  logic [CW-1:0] cnt;
  logic [31:0] dvd_mag, dvs_mag, quot, rem;
  res_t        exe_res, fix_res, flt_res, res_q;

  assign accept    = bus.in_valid & bus.in_ready;
  assign is_div_in = (bus.opc == CMD_DIV) | (bus.opc == CMD_IDIV);
  // #DE is decided from the raw operands so a faulting divide never enters the divider.
  assign fault_in  = is_div_in & ((bus.opnd1_r == 32'd0) |
                     ((bus.opc == CMD_IDIV) & (bus.opnd0_r == 32'h8000_0000) & (bus.opnd1_r == 32'hFFFF_FFFF)));
  assign accept_tgt = (is_div_in & ~fault_in) ? SEQ_DIV : SEQ_EXEC;
  assign div_load   = accept & is_div_in & ~fault_in;
  assign dvd_mag    = (bus.opc == CMD_IDIV) ? abs32(bus.opnd0_r) : bus.opnd0_r;
  assign dvs_mag    = (bus.opc == CMD_IDIV) ? abs32(bus.opnd1_r) : bus.opnd1_r;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= SEQ_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; DIV waits until the step counter reaches DIV_STEPS.
  always_comb begin
    state_nxt = state;
    case (state)
      SEQ_IDLE: if (bus.in_valid) state_nxt = accept_tgt;
      SEQ_EXEC: state_nxt = SEQ_HOLD;
      SEQ_DIV:  if (cnt == CW'(DIV_STEPS)) state_nxt = SEQ_FIX;
      SEQ_FIX:  state_nxt = SEQ_HOLD;
      SEQ_HOLD: if (bus.out_ready) state_nxt = bus.in_valid ? accept_tgt : SEQ_IDLE;
      default:  state_nxt = SEQ_IDLE;
    endcase
  end

  // State-decoded handshakes and datapath strobes.
  always_comb begin
    bus.in_ready  = (state == SEQ_IDLE) | ((state == SEQ_HOLD) & bus.out_ready);
    bus.out_valid = (state == SEQ_HOLD);
    en_div        = (state == SEQ_DIV) & (cnt != CW'(DIV_STEPS));
    load_res      = (state == SEQ_EXEC) | (state == SEQ_FIX);
  end

  // Capture every input on accept only; decode may change them freely afterwards.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      opc_q <= '0; eflags_q <= '0; eip_q <= '0; len_q <= '0; ecxz_q <= 1'b0;
      op0_q <= '0; op1_q <= '0; op2_q <= '0;
      fault_q <= 1'b0; qneg_q <= 1'b0; rneg_q <= 1'b0;
    end else if (accept) begin
      opc_q    <= bus.opc;
      eflags_q <= bus.eflags;
      eip_q    <= bus.eip;
      len_q    <= bus.instr_len;
      ecxz_q   <= bus.ecx_is_zero;
      op0_q    <= bus.opnd0_r;
      op1_q    <= bus.opnd1_r;
      op2_q    <= bus.opnd2_r;
      fault_q  <= fault_in;
      qneg_q   <= (bus.opc == CMD_IDIV) & (bus.opnd0_r[31] ^ bus.opnd1_r[31]);
      rneg_q   <= (bus.opc == CMD_IDIV) & bus.opnd0_r[31];
    end
  end

  // Divider step counter, restarted on every accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         cnt <= '0;
    else if (accept) cnt <= '0;
    else if (en_div) cnt <= cnt + 1'b1;
  end

  div_iter #(.W(32)) u_div (
    .clk      (clk),
    .rst      (rst),
    .load     (div_load),
    .en       (en_div),
    .dividend (dvd_mag),
    .divisor  (dvs_mag),
    .quot     (quot),
    .rem      (rem)
  );

  execute u_exe (
    .opc         (opc_q),
    .eflags      (eflags_q),
    .ecx_is_zero (ecxz_q),
    .eip         (eip_q),
    .instr_len   (len_q),
    .opnd0       (op0_q),
    .opnd1       (op1_q),
    .opnd2       (op2_q),
    .res         (exe_res)
  );

  // Signed fix-up of the unsigned divider result; flags untouched.
  assign fix_res.eflags   = eflags_q;
  assign fix_res.next_eip = eip_q + {28'd0, len_q};
  assign fix_res.opnd0    = qneg_q ? (~quot + 32'd1) : quot;
  assign fix_res.opnd1    = rneg_q ? (~rem + 32'd1) : rem;

  // Faulting divide echoes operands and does not advance EIP.
  assign flt_res.eflags   = eflags_q;
  assign flt_res.next_eip = eip_q;
  assign flt_res.opnd0    = op0_q;
  assign flt_res.opnd1    = op1_q;

  // Result register, loaded on the way into HOLD and held there until consumed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_q      <= '0;
      fault_de_q <= 1'b0;
    end else if (load_res) begin
      res_q      <= (state == SEQ_FIX) ? fix_res : (fault_q ? flt_res : exe_res);
      fault_de_q <= (state == SEQ_EXEC) & fault_q;
    end
  end

  assign bus.o_eflags = res_q.eflags;
  assign bus.next_eip = res_q.next_eip;
  assign bus.opnd0_w  = res_q.opnd0;
  assign bus.opnd1_w  = res_q.opnd1;
  assign bus.fault_de = fault_de_q;

`ifdef EXEC_SEQ_PERF_EN
  // Retired-step and divider-occupancy counters, free-running and wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_retired    <= '0;
      perf_div_cycles <= '0;
    end else begin
      if (bus.out_valid & bus.out_ready) perf_retired <= perf_retired + 32'd1;
      if ((state == SEQ_DIV) | (state == SEQ_FIX)) perf_div_cycles <= perf_div_cycles + 32'd1;
    end
  end
`endif

endmodule
